// File: rtl/ddc_cascade_pkg.sv
// Shared constants and helpers for the halfband decimation chain.
package ddc_cascade_pkg;

    localparam int TAP_CENTER = 16;
    localparam int TAP_NEAR   = 9;
    localparam int TAP_FAR    = -1;
    localparam int ROUND_BIAS = 16;
    localparam int SHIFT      = 5;
    localparam int ACC_GUARD  = 6;
    localparam int N_TAPS     = 7;

    // Clamp a wide signed value into a signed field of the given width.
    // The caller narrows the result to that width and also receives the clip bit.
    function automatic logic signed [63:0] saturate(
        input  logic signed [63:0] val,
        input  int unsigned        width,
        output logic               clip
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi   = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo   = ~hi;
        clip = 1'b0;
        saturate = val;
        if (val > hi) begin
            saturate = hi;
            clip     = 1'b1;
        end else if (val < lo) begin
            saturate = lo;
            clip     = 1'b1;
        end
    endfunction

endpackage

// File: rtl/ddc_hb_stage.sv
// One 7-tap halfband decimate-by-2 stage with rounding, saturation and an output register.
// Latency: output valid the cycle after the accepting edge of every second input.
// Backpressure: input stalls only on a result-producing input while the output register is full and not draining.
module ddc_hb_stage
    import ddc_cascade_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic signed [DATA_WIDTH-1:0] in_dat,
    input  logic                         in_vld,
    output logic                         in_rdy,
    output logic signed [DATA_WIDTH-1:0] out_dat,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic                         sat_hit
);

    localparam int ACC_W = DATA_WIDTH + ACC_GUARD;

    // hist[k] holds d[k] before the shift; after the shift d[0] is in_dat and d[k] is hist[k-1].
    logic signed [DATA_WIDTH-1:0] hist [N_TAPS-1];
    logic                         phase;
    logic signed [ACC_W-1:0]      acc;
    logic signed [ACC_W-1:0]      rounded;
    logic signed [DATA_WIDTH-1:0] y;
    logic                         clip;
    logic                         accept;
    logic                         produce;

    assign in_rdy  = !phase || !out_vld || out_rdy;
    assign accept  = in_vld && in_rdy;
    assign produce = accept && phase;
    assign sat_hit = produce && clip;

    always_comb begin
        acc = ACC_W'(TAP_CENTER) * ACC_W'(hist[2])
            + ACC_W'(TAP_NEAR)   * (ACC_W'(hist[1]) + ACC_W'(hist[3]))
            + ACC_W'(TAP_FAR)    * (ACC_W'(in_dat)  + ACC_W'(hist[5]));
        rounded = (acc + ACC_W'(ROUND_BIAS)) >>> SHIFT;
        clip    = 1'b0;
        y       = DATA_WIDTH'(saturate(64'(rounded), DATA_WIDTH, clip));
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int k = 0; k < N_TAPS - 1; k++) hist[k] <= '0;
            phase   <= 1'b0;
            out_vld <= 1'b0;
            out_dat <= '0;
        end else begin
            if (accept) begin
                hist[0] <= in_dat;
                for (int k = 1; k < N_TAPS - 1; k++) hist[k] <= hist[k-1];
                phase <= ~phase;
            end
            if (produce) begin
                out_dat <= y;
                out_vld <= 1'b1;
            end else if (out_rdy) begin
                out_vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ddc_cascade.sv
// Run-time selectable cascade of halfband decimators (overall decimation 2^dec_sel).
// Latency: one cycle per active stage after the final contributing input; zero in bypass.
// Backpressure: full valid/ready through every stage; cfg_load drops both handshakes for its cycle.
module ddc_cascade
    import ddc_cascade_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int N_STAGES   = 3,
    parameter int SEL_WIDTH  = $clog2(N_STAGES + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_load,
    input  logic [SEL_WIDTH-1:0]         dec_sel,
    input  logic signed [DATA_WIDTH-1:0] src_data_in,
    input  logic                         src_valid_in,
    output logic                         src_ready_out,
    output logic signed [DATA_WIDTH-1:0] dst_data_out,
    output logic                         dst_valid_out,
    input  logic                         dst_ready_in,
    output logic [N_STAGES-1:0]          sat_flags
);

    logic [SEL_WIDTH-1:0]         dec_sel_q;
    logic [SEL_WIDTH-1:0]         sel_clamped;
    logic                         bypass;
    logic signed [DATA_WIDTH-1:0] st_in_dat [N_STAGES];
    logic signed [DATA_WIDTH-1:0] st_dat    [N_STAGES];
    logic [N_STAGES-1:0]          st_in_vld;
    logic [N_STAGES-1:0]          st_in_rdy;
    logic [N_STAGES-1:0]          st_vld;
    logic [N_STAGES-1:0]          st_out_rdy;
    logic [N_STAGES-1:0]          st_sat;
    logic signed [DATA_WIDTH-1:0] tail_dat;
    logic                         tail_vld;

    assign sel_clamped = (dec_sel > SEL_WIDTH'(N_STAGES)) ? SEL_WIDTH'(N_STAGES) : dec_sel;
    assign bypass      = (dec_sel_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_sel_q <= SEL_WIDTH'(N_STAGES);
            sat_flags <= '0;
        end else if (cfg_load) begin
            dec_sel_q <= sel_clamped;
            sat_flags <= '0;
        end else begin
            sat_flags <= sat_flags | st_sat;
        end
    end

    // Stages at or beyond dec_sel_q see no valid and no ready, so they stay in reset state.
    for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign st_in_dat[i] = src_data_in;
            assign st_in_vld[i] = src_valid_in && !bypass && !cfg_load;
        end else begin : g_link
            assign st_in_dat[i] = st_dat[i-1];
            assign st_in_vld[i] = st_vld[i-1] && (SEL_WIDTH'(i) < dec_sel_q) && !cfg_load;
        end

        if (i == N_STAGES - 1) begin : g_last
            assign st_out_rdy[i] = (SEL_WIDTH'(i + 1) == dec_sel_q) && dst_ready_in;
        end else begin : g_mid
            assign st_out_rdy[i] = (SEL_WIDTH'(i + 1) == dec_sel_q) ? dst_ready_in :
                                   ((SEL_WIDTH'(i + 1) < dec_sel_q) && st_in_rdy[i+1]);
        end

        ddc_hb_stage #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .flush   (cfg_load),
            .in_dat  (st_in_dat[i]),
            .in_vld  (st_in_vld[i]),
            .in_rdy  (st_in_rdy[i]),
            .out_dat (st_dat[i]),
            .out_vld (st_vld[i]),
            .out_rdy (st_out_rdy[i]),
            .sat_hit (st_sat[i])
        );
    end

    always_comb begin
        tail_dat = '0;
        tail_vld = 1'b0;
        for (int i = 0; i < N_STAGES; i++) begin
            if (SEL_WIDTH'(i + 1) == dec_sel_q) begin
                tail_dat = st_dat[i];
                tail_vld = st_vld[i];
            end
        end
    end

    assign src_ready_out = !rst && !cfg_load && (bypass ? dst_ready_in : st_in_rdy[0]);
    assign dst_valid_out = !rst && !cfg_load && (bypass ? src_valid_in : tail_vld);
    assign dst_data_out  = rst ? '0 : (bypass ? src_data_in : tail_dat);

endmodule

// File: tb/tb_ddc_cascade.sv
// Directed bench for ddc_cascade: reset, impulse, DC, Nyquist, saturation, backpressure, reconfig, reset mid-stream.
module tb_ddc_cascade;

    localparam int DW = 16;
    localparam int NS = 3;
    localparam int SW = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_load;
    logic [SW-1:0]        dec_sel;
    logic signed [DW-1:0] src_data_in;
    logic                 src_valid_in;
    logic                 src_ready_out;
    logic signed [DW-1:0] dst_data_out;
    logic                 dst_valid_out;
    logic                 dst_ready_in;
    logic [NS-1:0]        sat_flags;

    ddc_cascade #(
        .DATA_WIDTH (DW),
        .N_STAGES   (NS),
        .SEL_WIDTH  (SW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_load      (cfg_load),
        .dec_sel       (dec_sel),
        .src_data_in   (src_data_in),
        .src_valid_in  (src_valid_in),
        .src_ready_out (src_ready_out),
        .dst_data_out  (dst_data_out),
        .dst_valid_out (dst_valid_out),
        .dst_ready_in  (dst_ready_in),
        .sat_flags     (sat_flags)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int got[$];
    bit stab_en    = 1'b0;
    bit prev_stall = 1'b0;
    logic signed [DW-1:0] prev_dat = '0;

    task automatic check_eq(input string tag, input longint act, input longint exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Output collector and hold-while-stalled monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (stab_en && prev_stall) begin
            check_eq("stall_valid", longint'(dst_valid_out), 1);
            check_eq("stall_data", longint'(dst_data_out), longint'(prev_dat));
        end
        prev_stall = stab_en && dst_valid_out && !dst_ready_in;
        prev_dat   = dst_data_out;
        if (dst_valid_out && dst_ready_in) got.push_back(int'(dst_data_out));
    end

    function automatic int qget(input int idx);
        return (idx < got.size()) ? got[idx] : -999999;
    endfunction

    function automatic void hb_model(input int x[$], output int y[$]);
        int d[7];
        int acc;
        int v;
        y.delete();
        for (int n = 2; n <= x.size(); n += 2) begin
            for (int k = 0; k < 7; k++) d[k] = (n - 1 - k >= 0) ? x[n-1-k] : 0;
            acc = 16 * d[3] + 9 * (d[2] + d[4]) - (d[0] + d[6]);
            v = (acc + 16) >>> 5;
            if (v > 32767) v = 32767;
            else if (v < -32768) v = -32768;
            y.push_back(v);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        src_valid_in = 1'b0;
        dst_ready_in = 1'b1;
        repeat (n) tick();
    endtask

    task automatic do_cfg(input int sel);
        src_valid_in = 1'b0;
        cfg_load     = 1'b1;
        dec_sel      = SW'(sel);
        tick();
        cfg_load     = 1'b0;
        got.delete();
    endtask

    task automatic stream(input int vals[$], input bit rnd, output int sent);
        int  cyc;
        bit  took;
        cyc  = 0;
        sent = 0;
        src_valid_in = 1'b0;
        while (sent < vals.size() && cyc < 4000) begin
            if (!src_valid_in) src_valid_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            src_data_in  = DW'(vals[sent]);
            dst_ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            took = src_valid_in && src_ready_out;
            tick();
            if (took) begin
                sent++;
                src_valid_in = 1'b0;
            end
            cyc++;
        end
        src_valid_in = 1'b0;
    endtask

    int vals[$];
    int model1[$];
    int model2[$];
    int model3[$];
    int sent;

    initial begin
        rst          = 1'b1;
        cfg_load     = 1'b0;
        dec_sel      = '0;
        src_data_in  = '0;
        src_valid_in = 1'b1;
        dst_ready_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_src_ready", longint'(src_ready_out), 0);
        check_eq("rst_dst_valid", longint'(dst_valid_out), 0);
        check_eq("rst_dst_data", longint'(dst_data_out), 0);
        check_eq("rst_sat", longint'(sat_flags), 0);
        tick();
        rst          = 1'b0;
        src_valid_in = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", longint'(src_ready_out), 1);
        tick();

        // Impulse through one stage.
        do_cfg(1);
        vals.delete();
        for (int i = 0; i < 8; i++) vals.push_back(i == 1 ? 32 : 0);
        stream(vals, 1'b0, sent);
        idle(8);
        check_eq("imp_count", got.size(), 4);
        check_eq("imp_y0", qget(0), -1);
        check_eq("imp_y1", qget(1), 9);
        check_eq("imp_y2", qget(2), 9);
        check_eq("imp_y3", qget(3), -1);

        // Nyquist tone is rejected once the delay line is full.
        do_cfg(1);
        vals.delete();
        for (int i = 0; i < 16; i++) vals.push_back((i % 2 == 0) ? 8000 : -8000);
        stream(vals, 1'b0, sent);
        idle(8);
        check_eq("nyq_count", got.size(), 8);
        check_eq("nyq_warm", qget(2), -250);
        for (int i = 3; i < 8; i++) check_eq("nyq_zero", qget(i), 0);

        // Saturation and sticky flag.
        do_cfg(1);
        vals.delete();
        for (int i = 0; i < 8; i++)
            vals.push_back(i == 0 ? 0 : ((i == 1 || i == 7) ? -32768 : 32767));
        stream(vals, 1'b0, sent);
        idle(4);
        check_eq("sat_count", got.size(), 4);
        check_eq("sat_y0", qget(0), 1024);
        check_eq("sat_y1", qget(1), -10240);
        check_eq("sat_y2", qget(2), 15359);
        check_eq("sat_y3", qget(3), 32767);
        check_eq("sat_flag", longint'(sat_flags), 1);
        idle(6);
        check_eq("sat_sticky", longint'(sat_flags), 1);
        do_cfg(1);
        check_eq("sat_clear", longint'(sat_flags), 0);

        // DC through two stages.
        do_cfg(2);
        vals.delete();
        for (int i = 0; i < 40; i++) vals.push_back(1000);
        stream(vals, 1'b0, sent);
        idle(10);
        check_eq("dc_count", got.size(), 10);
        for (int i = 4; i < 10; i++) check_eq("dc_value", qget(i), 1000);
        check_eq("dc_sat", longint'(sat_flags), 0);

        // Random valid/ready over three stages against the golden chain.
        do_cfg(3);
        vals.delete();
        for (int i = 0; i < 64; i++) vals.push_back(i * 400 - 12000);
        hb_model(vals, model1);
        hb_model(model1, model2);
        hb_model(model2, model3);
        stab_en = 1'b1;
        stream(vals, 1'b1, sent);
        check_eq("bp_sent", sent, 64);
        idle(20);
        stab_en = 1'b0;
        check_eq("bp_count", got.size(), model3.size());
        for (int i = 0; i < model3.size(); i++) check_eq("bp_value", qget(i), model3[i]);

        // cfg_load to bypass mid-stream.
        do_cfg(2);
        vals.delete();
        for (int i = 0; i < 12; i++) vals.push_back(300 + i);
        stream(vals, 1'b0, sent);
        src_valid_in = 1'b1;
        src_data_in  = 16'sd500;
        dst_ready_in = 1'b1;
        cfg_load     = 1'b1;
        dec_sel      = '0;
        @(negedge clk);
        check_eq("cfg_src_ready", longint'(src_ready_out), 0);
        check_eq("cfg_dst_valid", longint'(dst_valid_out), 0);
        tick();
        cfg_load     = 1'b0;
        src_data_in  = 16'sd1234;
        dst_ready_in = 1'b0;
        @(negedge clk);
        check_eq("byp_valid", longint'(dst_valid_out), 1);
        check_eq("byp_data", longint'(dst_data_out), 1234);
        check_eq("byp_ready_lo", longint'(src_ready_out), 0);
        dst_ready_in = 1'b1;
        src_data_in  = -16'sd77;
        #1;
        check_eq("byp_ready_hi", longint'(src_ready_out), 1);
        check_eq("byp_data_neg", longint'(dst_data_out), -77);
        tick();

        // Reset mid-stream with a result held by backpressure.
        do_cfg(1);
        vals.delete();
        for (int i = 0; i < 8; i++)
            vals.push_back(i == 0 ? 0 : ((i == 1 || i == 7) ? -32768 : 32767));
        stream(vals, 1'b0, sent);
        src_valid_in = 1'b1;
        src_data_in  = 16'sd100;
        dst_ready_in = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check_eq("pre_rst_valid", longint'(dst_valid_out), 1);
        check_eq("pre_rst_sat", longint'(sat_flags), 1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_ready", longint'(src_ready_out), 0);
        tick();
        rst          = 1'b0;
        src_valid_in = 1'b0;
        @(negedge clk);
        check_eq("post_rst_valid", longint'(dst_valid_out), 0);
        check_eq("post_rst_data", longint'(dst_data_out), 0);
        check_eq("post_rst_sat", longint'(sat_flags), 0);
        check_eq("post_rst_ready2", longint'(src_ready_out), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ddc_cascade.md
# ddc_cascade

Parametrised digital down-converter decimation chain. Up to N_STAGES cascaded 7-tap halfband decimate-by-2 stages, with the number of active stages selected at run time (overall decimation 2^dec_sel). Full valid/ready backpressure through every stage, per-stage saturation with sticky overflow flags. Sits between the ADC sample interface and the baseband consumer; replaces the fixed three-stage chain whose ready was a pure pass-through.

## Interface
- DATA_WIDTH, 16: signed sample width at input, between stages, and at output.
- N_STAGES, 3: number of physical halfband stages (1..6).
- SEL_WIDTH, $clog2(N_STAGES+1): width of dec_sel.
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- cfg_load  in  1  one-cycle pulse; latches dec_sel and flushes the chain.
- dec_sel  in  SEL_WIDTH  number of active stages; values > N_STAGES clamp to N_STAGES.
- src_data_in  in  DATA_WIDTH  signed input sample.
- src_valid_in  in  1  input valid.
- src_ready_out  out  1  chain accepts input this cycle.
- dst_data_out  out  DATA_WIDTH  signed decimated sample.
- dst_valid_out  out  1  output valid; held with stable data until accepted.
- dst_ready_in  in  1  downstream ready.
- sat_flags  out  N_STAGES  sticky per-stage saturation flags.

## Operation
- Transfer on any interface occurs when valid && ready at the rising edge.
- Stage: 7-sample delay line d[0..6] (d[0] newest), shifts on every accepted input; phase bit toggles per accepted input.
- On an accepted input that sets phase to 1 (2nd, 4th, ... since flush), after the shift: acc = 16*d[3] + 9*(d[2]+d[4]) - (d[0]+d[6]); acc width DATA_WIDTH+6; y = (acc + 16) >>> 5 (round half up); saturate to DATA_WIDTH; any clip sets that stage's sat_flags bit.
- y loaded into the stage output register (valid). Unity DC gain (taps sum 32).
- Stage accepts input when phase==0, or when its output register is empty or being drained this cycle.
- Active stages 0..dec_sel_q-1 are chained; dst_* is taken from stage dec_sel_q-1. Inactive stages hold reset state, receive no data.
- dec_sel_q==0: pure bypass, dst_data_out=src_data_in, dst_valid_out=src_valid_in, src_ready_out=dst_ready_in (combinational).
- cfg_load: dec_sel_q <= clamped dec_sel; all delay lines, phases, output valids and sat_flags cleared; in-flight data discarded; src_ready_out=0 and dst_valid_out=0 in the cfg_load cycle.

## Timing
- Reset values: dst_valid_out=0, dst_data_out=0, sat_flags=0, src_ready_out=0 while rst high, dec_sel_q=N_STAGES, delay lines and phases zero.
- First-cycle-after-reset: src_ready_out=1.
- Per-stage latency: output valid the cycle after the accepting edge of its phase-1 input; chain latency = dec_sel_q cycles from the final contributing input.
- Throughput: one input per cycle sustained when dst_ready_in=1.
- Stall: dst_ready_in low holds last stage; backpressure propagates one stage per phase-1 input; no sample lost or duplicated; dst_data_out stable while dst_valid_out && !dst_ready_in.
- Simultaneous output drain and new phase-1 result on a stage: register reloads same cycle, valid stays 1.
- rst overrides cfg_load; cfg_load overrides data transfer the same cycle.

## Structure
- Package ddc_cascade_pkg: tap constants (16, 9, -1), ROUND_BIAS=16, SHIFT=5, ACC_GUARD=6, saturate function (acc width -> DATA_WIDTH, returns value and clip bit).
- Sub-module ddc_hb_stage: one delay line, phase bit, MAC, round/saturate, output register with valid/ready; generate loop instantiates N_STAGES; top holds dec_sel_q, output mux, ready mux, sat_flags.

## Test plan
- DC: dec_sel=2, constant 1000 continuous, dst_ready_in=1 -> after settling every output = 1000, one output per 4 inputs, sat_flags=0.
- Impulse: dec_sel=1 after cfg_load, inputs 0,32,0,0,0,0,0,0 -> outputs -1, 9, 9, -1.
- Nyquist: dec_sel=1, alternating +8000/-8000 -> outputs after warm-up = 0.
- Saturation: dec_sel=1, d[0..6] = -32768,32767,32767,32767,32767,32767,-32768 -> output 32767, sat_flags[0]=1 until next cfg_load.
- Backpressure: dec_sel=3, random src_valid_in and dst_ready_in (50%), ramp input -> output sequence equals golden model, no loss/duplication, data stable during stalls.
- Reconfig/reset: cfg_load dec_sel=0 mid-stream -> same cycle ready/valid 0, then combinational bypass; rst mid-stream -> all outputs at reset values next cycle.
